// File: rtl/ten_gig_xgmii_tx_encoder_pkg.sv
// Shared constants and helpers for the 10G XGMII transmit encoder.
package ten_gig_xgmii_pkg;

  localparam logic [7:0]  C_XGMII_IDLE    = 8'h07;
  localparam logic [7:0]  C_START         = 8'hFB;
  localparam logic [7:0]  C_TERM          = 8'hFD;
  localparam logic [7:0]  C_ERROR         = 8'hFE;
  localparam logic [63:0] C_PREAMBLE_WORD = 64'hFB55_5555_5555_55D5;
  localparam logic [63:0] C_IDLE_WORD     = {8{C_XGMII_IDLE}};
  localparam logic [63:0] C_ERROR_WORD    = {8{C_ERROR}};
  localparam logic [31:0] C_CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] C_CRC_POLY_REFL = 32'hEDB8_8320;

  // Encoder FSM states
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_TAIL  = 3'd3;
  localparam logic [2:0] S_IPG   = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;

  // Number of leading ones in tkeep; anything after the first zero is ignored.
  function automatic logic [3:0] lead_ones(input logic [7:0] keep);
    logic [3:0] n;
    logic       run;
    n   = 4'd0;
    run = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      run = run & keep[i];
      n   = n + {3'b000, run};
    end
    return n;
  endfunction

endpackage

// File: rtl/ten_gig_xgmii_tx_encoder_if.sv
// AXI-Stream input and XGMII output bundle of the transmit encoder.
interface ten_gig_xgmii_tx_encoder_if;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] o_xgmii_txd;
  logic [7:0]  o_xgmii_txc;
  logic        o_frame_done;
  logic        o_underrun;

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
    input  s_axis_tready, o_xgmii_txd, o_xgmii_txc, o_frame_done, o_underrun
  );

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
    output s_axis_tready, o_xgmii_txd, o_xgmii_txc, o_frame_done, o_underrun
  );
endinterface

// File: rtl/ten_gig_xgmii_tx_encoder_crc32_d64.sv
// Combinational next-CRC32 (reflected 802.3) over up to 8 bytes, lane 0 (MSB byte) first.
module crc32_d64
  import ten_gig_xgmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [63:0] data,
  input  logic [3:0]  nbytes,
  output logic [31:0] crc_out
);

  logic fb;

  // Bit-serial reflected update, unrolled; each byte is consumed LSB first.
  always_comb begin
    crc_out = crc_in;
    fb      = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nbytes) begin
        for (int b = 0; b < 8; b++) begin
          fb      = crc_out[0] ^ data[56 - 8*i + b];
          crc_out = {1'b0, crc_out[31:1]} ^ (fb ? C_CRC_POLY_REFL : 32'h0);
        end
      end
    end
  end

endmodule

// File: rtl/ten_gig_xgmii_tx_encoder.sv
// 10G MAC transmit encoder: AXI-Stream frame -> XGMII words with preamble, FCS, terminate and IPG.
module ten_gig_xgmii_tx_encoder
  import ten_gig_xgmii_pkg::*;
#(
  parameter int P_IPG_BYTES = 12
) (
  input logic i_clk,
  input logic i_rst_n,
  ten_gig_xgmii_tx_encoder_if.slave bus
);

  logic [2:0]       state, state_n;
  logic [31:0]      crc, crc_n, crc_calc, fcs;
  logic [7:0]       ipg_cnt, ipg_n, ipg_sat;
  logic [63:0]      txd, txd_n, tail_d, tail_d_n;
  logic [7:0]       txc, txc_n, tail_c, tail_c_n;
  logic             tready, tready_n, done, done_n, unr, unr_n;
  logic [3:0]       nkeep, crc_nb;
  logic [7:0][7:0]  tdata_v;
  logic [3:0][7:0]  fcs_v;
  logic [15:0][7:0] lane_d;   // lane p of the last word and its overflow at element 15-p
  logic [15:0]      lane_c;
  int               q;

  assign tdata_v = bus.s_axis_tdata;
  assign nkeep   = lead_ones(bus.s_axis_tkeep);
  assign crc_nb  = bus.s_axis_tlast ? nkeep : 4'd8;
  assign fcs     = ~crc_calc;
  assign fcs_v   = fcs;
  assign ipg_sat = (ipg_cnt > 8'd247) ? 8'hFF : ipg_cnt + 8'd8;

  crc32_d64 u_crc (
    .crc_in (crc),
    .data   (bus.s_axis_tdata),
    .nbytes (crc_nb),
    .crc_out(crc_calc)
  );

  // Lay out the frame end as a 16-lane stream: kept data, FCS (LSB first), FD, idle fill.
  always_comb begin
    lane_d = '0;
    lane_c = '0;
    q      = 0;
    for (int p = 0; p < 16; p++) begin
      q = p - int'(nkeep);
      if (q < 0) begin
        lane_d[4'(15 - p)] = tdata_v[3'(7 - p)];
        lane_c[4'(15 - p)] = 1'b0;
      end else if (q < 4) begin
        lane_d[4'(15 - p)] = fcs_v[2'(q)];
        lane_c[4'(15 - p)] = 1'b0;
      end else if (q == 4) begin
        lane_d[4'(15 - p)] = C_TERM;
        lane_c[4'(15 - p)] = 1'b1;
      end else begin
        lane_d[4'(15 - p)] = C_XGMII_IDLE;
        lane_c[4'(15 - p)] = 1'b1;
      end
    end
  end

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_n  = state;
    crc_n    = crc;
    ipg_n    = ipg_cnt;
    txd_n    = C_IDLE_WORD;
    txc_n    = 8'hFF;
    done_n   = 1'b0;
    unr_n    = 1'b0;
    tail_d_n = tail_d;
    tail_c_n = tail_c;
    case (state)
      S_IDLE: begin
        if (bus.s_axis_tvalid && int'(ipg_cnt) >= P_IPG_BYTES) begin
          state_n = S_PRE;
          txd_n   = C_PREAMBLE_WORD;
          txc_n   = 8'h80;
          crc_n   = C_CRC_INIT;
        end else begin
          ipg_n = ipg_sat;
        end
      end
      S_IPG: begin
        // Exit on the count including this idle word so the gap stays minimal.
        ipg_n = ipg_sat;
        if (int'(ipg_sat) >= P_IPG_BYTES) state_n = S_IDLE;
      end
      S_PRE, S_DATA: begin
        if (!bus.s_axis_tvalid) begin
          state_n = S_ERR;
          txd_n   = C_ERROR_WORD;
          unr_n   = 1'b1;
          ipg_n   = 8'd0;
        end else if (!bus.s_axis_tlast) begin
          state_n = S_DATA;
          txd_n   = bus.s_axis_tdata;
          txc_n   = 8'h00;
          crc_n   = crc_calc;
        end else begin
          txd_n    = lane_d[15:8];
          txc_n    = lane_c[15:8];
          tail_d_n = lane_d[7:0];
          tail_c_n = lane_c[7:0];
          crc_n    = C_CRC_INIT;
          if (nkeep <= 4'd3) begin
            state_n = S_IPG;
            done_n  = 1'b1;
            ipg_n   = 8'($countones(lane_c[15:8])) - 8'd1;
          end else begin
            state_n = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        state_n = S_IPG;
        txd_n   = tail_d;
        txc_n   = tail_c;
        done_n  = 1'b1;
        ipg_n   = 8'($countones(tail_c)) - 8'd1;
      end
      S_ERR: begin
        state_n = S_DRAIN;
        ipg_n   = ipg_sat;
        crc_n   = C_CRC_INIT;
      end
      S_DRAIN: begin
        ipg_n = ipg_sat;
        if (bus.s_axis_tvalid && bus.s_axis_tlast) state_n = S_IPG;
      end
      default: state_n = S_IDLE;
    endcase
    tready_n = (state_n == S_PRE) || (state_n == S_DATA) || (state_n == S_DRAIN);
  end

  // State, CRC, IPG counter and output registers; reset truncates any frame in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      crc     <= C_CRC_INIT;
      ipg_cnt <= 8'hFF;
      txd     <= C_IDLE_WORD;
      txc     <= 8'hFF;
      tready  <= 1'b0;
      done    <= 1'b0;
      unr     <= 1'b0;
      tail_d  <= C_IDLE_WORD;
      tail_c  <= 8'hFF;
    end else begin
      state   <= state_n;
      crc     <= crc_n;
      ipg_cnt <= ipg_n;
      txd     <= txd_n;
      txc     <= txc_n;
      tready  <= tready_n;
      done    <= done_n;
      unr     <= unr_n;
      tail_d  <= tail_d_n;
      tail_c  <= tail_c_n;
    end
  end

  assign bus.s_axis_tready = tready;
  assign bus.o_xgmii_txd   = txd;
  assign bus.o_xgmii_txc   = txc;
  assign bus.o_frame_done  = done;
  assign bus.o_underrun    = unr;

endmodule

// File: tb/tb_ten_gig_xgmii_tx_encoder.sv
// Scoreboard bench for the XGMII transmit encoder: expected words queued at stimulus time.
module tb_ten_gig_xgmii_tx_encoder;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
    logic        done;
    logic        unr;
  } word_t;

  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  word_t exp_q[$];
  word_t obs_q[$];
  int    gap_q[$];
  bit    counting = 0;
  int    gap = 0;
  bit    gap_rdy_bad = 0;
  word_t mw;

  ten_gig_xgmii_tx_encoder_if bus ();

  ten_gig_xgmii_tx_encoder #(.P_IPG_BYTES(12)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Output monitor: keeps every non-idle word, and measures idle bytes from FD lane to next FB.
  always @(negedge clk) begin
    if (rst_n) begin
      mw.d    = bus.o_xgmii_txd;
      mw.c    = bus.o_xgmii_txc;
      mw.done = bus.o_frame_done;
      mw.unr  = bus.o_underrun;
      if (mw.d != {8{8'h07}} || mw.c != 8'hFF || mw.done || mw.unr) obs_q.push_back(mw);
      for (int k = 0; k < 8; k++) begin
        if (mw.c[7-k] && mw.d[63-8*k -: 8] == 8'hFD) begin
          counting = 1; gap = 0;
        end else if (mw.c[7-k] && mw.d[63-8*k -: 8] == 8'hFB) begin
          if (counting) gap_q.push_back(gap);
          counting = 0;
        end else if (counting && mw.c[7-k] && mw.d[63-8*k -: 8] == 8'h07) begin
          gap++;
        end
      end
      if (counting && bus.s_axis_tready) gap_rdy_bad = 1;
    end
  end

  function automatic logic [31:0] crc32(input logic [7:0] fr[$]);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (fr[i]) begin
      c = c ^ {24'h0, fr[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Serialise the whole frame as the byte stream the link should carry, then cut into words.
  task automatic expect_frame(input logic [7:0] fr[$]);
    logic [7:0]  sb[$];
    bit          sc[$];
    logic [31:0] f;
    word_t       w;
    f = crc32(fr);
    sb.push_back(8'hFB); sc.push_back(1);
    repeat (6) begin sb.push_back(8'h55); sc.push_back(0); end
    sb.push_back(8'hD5); sc.push_back(0);
    foreach (fr[i]) begin sb.push_back(fr[i]); sc.push_back(0); end
    for (int i = 0; i < 4; i++) begin sb.push_back(f[8*i +: 8]); sc.push_back(0); end
    sb.push_back(8'hFD); sc.push_back(1);
    while (sb.size() % 8 != 0) begin sb.push_back(8'h07); sc.push_back(1); end
    for (int wi = 0; wi < sb.size() / 8; wi++) begin
      w = '0;
      for (int k = 0; k < 8; k++) begin
        w.d[63-8*k -: 8] = sb[wi*8+k];
        w.c[7-k]         = sc[wi*8+k];
        if (sc[wi*8+k] && sb[wi*8+k] == 8'hFD) w.done = 1;
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic last);
    int g = 0;
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = k;
    bus.s_axis_tlast  = last;
    bus.s_axis_tvalid = 1'b1;
    do begin @(negedge clk); g++; end while (bus.s_axis_tready !== 1'b1 && g < 500);
    if (bus.s_axis_tready !== 1'b1) begin
      n_assert++; n_fail++;
      $display("FAIL beat_accept: tready=%b after %0d cycles, required 1", bus.s_axis_tready, g);
    end
    @(posedge clk); #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  // drop_at >= 0: that beat is replaced by one cycle of tvalid=0.
  task automatic send_frame(input logic [7:0] fr[$], input logic [7:0] keep_ovr, input int drop_at);
    int nb;
    nb = (fr.size() + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      logic [63:0] d;
      logic [7:0]  k;
      int          rem;
      if (b == drop_at) begin
        @(posedge clk); #1;
      end else begin
        rem = fr.size() - 8*b;
        d = {$urandom, $urandom};
        k = 8'h00;
        for (int i = 0; i < 8; i++) if (i < rem) begin d[63-8*i -: 8] = fr[8*b+i]; k[7-i] = 1'b1; end
        if (b == nb - 1 && keep_ovr != 8'h00) k = keep_ovr;
        drive_beat(d, k, b == nb - 1);
      end
    end
  endtask

  task automatic wait_obs(output bit ok);
    int g = 0;
    while (obs_q.size() < exp_q.size() && g < 3000) begin @(negedge clk); g++; end
    repeat (2) @(negedge clk);
    ok = (obs_q.size() >= exp_q.size());
  endtask

  task automatic rand_frame(input int len, output logic [7:0] fr[$]);
    fr.delete();
    for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    bus.s_axis_tdata = '0; bus.s_axis_tkeep = '0; bus.s_axis_tlast = 0; bus.s_axis_tvalid = 0;
    #1 rst_n = 1'b0;
    #2;
    n_assert++; if (bus.o_xgmii_txd !== 64'h0707_0707_0707_0707) begin n_fail++; $display("FAIL reset_txd: got %h, required 0707070707070707", bus.o_xgmii_txd); end
    n_assert++; if (bus.o_xgmii_txc !== 8'hFF) begin n_fail++; $display("FAIL reset_txc: got %h, required ff", bus.o_xgmii_txc); end
    n_assert++; if (bus.s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b, required 0", bus.s_axis_tready); end
    n_assert++; if (bus.o_frame_done !== 1'b0 || bus.o_underrun !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got done=%b unr=%b, required 0 0", bus.o_frame_done, bus.o_underrun); end
    #19 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nine_byte;
    logic [7:0] fr[$];
    word_t e, o;
    bit ok;
    fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    exp_q.push_back('{64'hFB55_5555_5555_55D5, 8'h80, 1'b0, 1'b0});
    exp_q.push_back('{64'h3132_3334_3536_3738, 8'h00, 1'b0, 1'b0});
    exp_q.push_back('{64'h3926_39F4_CBFD_0707, 8'h07, 1'b1, 1'b0});
    send_frame(fr, 8'h00, -1);
    wait_obs(ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL nine_count: got %0d words, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL nine_word: got %h/%h d%b u%b, required %h/%h d%b u%b", o.d, o.c, o.done, o.unr, e.d, e.c, e.done, e.unr); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_keep_sweep;
    logic [7:0] fr[$];
    word_t e, o;
    bit ok;
    for (int n = 8; n >= 1; n--) begin
      rand_frame(72 + n, fr);
      expect_frame(fr);
      send_frame(fr, 8'h00, -1);
    end
    // Non-contiguous keep: only the two leading ones count.
    rand_frame(74, fr);
    expect_frame(fr);
    send_frame(fr, 8'hC5, -1);
    wait_obs(ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL sweep_count: got %0d words, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL sweep_word: got %h/%h d%b u%b, required %h/%h d%b u%b", o.d, o.c, o.done, o.unr, e.d, e.c, e.done, e.unr); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] f1[$], f2[$], f3[$];
    word_t e, o;
    bit ok;
    int m, need, exp_gap[2];
    int lens[2];
    lens = '{9, 12};
    for (int i = 0; i < 2; i++) begin
      m    = (8 - ((lens[i] + 13) % 8)) % 8;
      need = (12 - m > 0) ? (12 - m + 7) / 8 : 0;
      exp_gap[i] = m + 8 * need;
    end
    gap_rdy_bad = 0;
    rand_frame(9, f1); rand_frame(12, f2); rand_frame(9, f3);
    expect_frame(f1); expect_frame(f2); expect_frame(f3);
    send_frame(f1, 8'h00, -1);
    send_frame(f2, 8'h00, -1);
    send_frame(f3, 8'h00, -1);
    wait_obs(ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL b2b_count: got %0d words, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_word: got %h/%h d%b u%b, required %h/%h d%b u%b", o.d, o.c, o.done, o.unr, e.d, e.c, e.done, e.unr); end
    end
    exp_q.delete(); obs_q.delete();
    n_assert++;
    if (gap_q.size() < 2) begin
      n_fail++; $display("FAIL b2b_gaps: got %0d gaps, required at least 2", gap_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_assert++;
        if (gap_q[gap_q.size() - 2 + i] !== exp_gap[i] || gap_q[gap_q.size() - 2 + i] < 12) begin
          n_fail++; $display("FAIL b2b_ipg%0d: got %0d idle bytes, required %0d", i, gap_q[gap_q.size() - 2 + i], exp_gap[i]);
        end
      end
    end
    n_assert++; if (gap_rdy_bad !== 1'b0) begin n_fail++; $display("FAIL b2b_tready_gap: got tready high in gap, required low"); end
  endtask

  task automatic test_underrun;
    logic [7:0] fr[$], f2[$];
    word_t e, o, w;
    bit ok;
    rand_frame(80, fr);
    exp_q.push_back('{64'hFB55_5555_5555_55D5, 8'h80, 1'b0, 1'b0});
    for (int b = 0; b < 2; b++) begin
      w = '0;
      for (int k = 0; k < 8; k++) w.d[63-8*k -: 8] = fr[8*b+k];
      exp_q.push_back(w);
    end
    exp_q.push_back('{64'hFEFE_FEFE_FEFE_FEFE, 8'hFF, 1'b0, 1'b1});
    send_frame(fr, 8'h00, 2);
    rand_frame(20, f2);
    expect_frame(f2);
    send_frame(f2, 8'h00, -1);
    wait_obs(ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL underrun_count: got %0d words, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL underrun_word: got %h/%h d%b u%b, required %h/%h d%b u%b", o.d, o.c, o.done, o.unr, e.d, e.c, e.done, e.unr); end
    end
    repeat (6) @(negedge clk);
    n_assert++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL underrun_extra: got %0d extra words, required 0", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid;
    logic [7:0] fr[$];
    word_t e, o, w;
    bit ok;
    rand_frame(40, fr);
    exp_q.push_back('{64'hFB55_5555_5555_55D5, 8'h80, 1'b0, 1'b0});
    w = '0;
    for (int k = 0; k < 8; k++) w.d[63-8*k -: 8] = fr[k];
    exp_q.push_back(w);
    drive_beat({fr[0], fr[1], fr[2], fr[3], fr[4], fr[5], fr[6], fr[7]}, 8'hFF, 1'b0);
    drive_beat({fr[8], fr[9], fr[10], fr[11], fr[12], fr[13], fr[14], fr[15]}, 8'hFF, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    n_assert++; if (bus.o_xgmii_txd !== 64'h0707_0707_0707_0707) begin n_fail++; $display("FAIL rstmid_txd: got %h, required 0707070707070707", bus.o_xgmii_txd); end
    n_assert++; if (bus.o_xgmii_txc !== 8'hFF) begin n_fail++; $display("FAIL rstmid_txc: got %h, required ff", bus.o_xgmii_txc); end
    n_assert++; if (bus.s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL rstmid_tready: got %b, required 0", bus.s_axis_tready); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL rstmid_pre_word: got %h/%h d%b u%b, required %h/%h d%b u%b", o.d, o.c, o.done, o.unr, e.d, e.c, e.done, e.unr); end
    end
    n_assert++; if (exp_q.size() != 0 || obs_q.size() != 0) begin n_fail++; $display("FAIL rstmid_pre_count: got %0d words, required 2", 2 - exp_q.size() + obs_q.size()); end
    exp_q.delete(); obs_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    rand_frame(30, fr);
    expect_frame(fr);
    send_frame(fr, 8'h00, -1);
    wait_obs(ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL rstmid_count: got %0d words, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL rstmid_word: got %h/%h d%b u%b, required %h/%h d%b u%b", o.d, o.c, o.done, o.unr, e.d, e.c, e.done, e.unr); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_nine_byte();
    test_keep_sweep();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
